// File: rtl/mini_rmt_rd_ctrl.sv
// Core-side controller for non-local loads/stores: issues one fabric transaction at a time,
// stalls the core while it is outstanding and returns read data (or a timeout word) to the core.
package mini_rmt_pkg;

    typedef enum logic [2:0] {
        NULL_CARDINAL = 3'd0,
        NORTH         = 3'd1,
        EAST          = 3'd2,
        SOUTH         = 3'd3,
        WEST          = 3'd4
    } t_cardinal;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        WR     = 2'd1,
        RD_RSP = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef struct packed {
        t_cardinal   next_tile_fifo_arb_id;
        t_opcode     opcode;
        logic [7:0]  requestor_id;
        logic [31:0] address;
        logic [31:0] data;
    } t_tile_trans;

endpackage

module mini_rmt_rd_ctrl
    import mini_rmt_pkg::*;
#(
    parameter int          TMO_CYCLES = 1024,
    parameter int          TMO_CNT_W  = 11,
    parameter logic [31:0] TMO_DATA   = 32'hDEAD_BEEF
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic [7:0]  local_tile_id,
    input  logic [31:0] DMemAddressQ103H,
    input  logic [31:0] DMemWrDataQ103H,
    input  logic        DMemWrEnQ103H,
    input  logic        DMemRdEnQ103H,
    output logic        CoreStallQ103H,
    output logic        RmtRdRspValid,
    output logic [31:0] RmtRdRspData,
    output logic        C2fReqValid,
    output t_tile_trans C2fReq,
    input  logic        C2fReqReady,
    input  logic        InFabricValidQ503H,
    input  t_tile_trans InFabricQ503H,
    output logic        RspDropPulse,
    output logic        RdTmoErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RSP  = 2'd3
    } state_e;

    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_CYCLES - 1);

    state_e                 state_q, state_d;
    t_tile_trans            req_q, req_d;
    logic [TMO_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   tmo_err_q, tmo_err_d;

    logic [7:0] acc_tile;
    logic       rmt_hit;
    logic       fab_is_rd_rsp;
    logic       rsp_match;
    logic       core_stall;
    logic       drop_pulse;

    assign acc_tile = DMemAddressQ103H[31:24];
    assign rmt_hit  = (DMemWrEnQ103H || DMemRdEnQ103H)
                      && (acc_tile != local_tile_id) && (acc_tile != 8'h00);

    // A response is ours only if it targets this tile at the pending offset and
    // names the tile we sent the read to as its requestor.
    assign fab_is_rd_rsp = InFabricValidQ503H && (InFabricQ503H.opcode == RD_RSP);
    assign rsp_match     = fab_is_rd_rsp
                           && (InFabricQ503H.address[31:24] == local_tile_id)
                           && (InFabricQ503H.address[23:0] == req_q.address[23:0])
                           && (InFabricQ503H.requestor_id == req_q.address[31:24]);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        tmo_err_d   = tmo_err_q;
        core_stall  = 1'b0;
        drop_pulse  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rmt_hit) begin
                    core_stall                  = 1'b1;
                    req_d.next_tile_fifo_arb_id = NULL_CARDINAL;
                    req_d.opcode                = DMemWrEnQ103H ? WR : RD;
                    req_d.requestor_id          = local_tile_id;
                    req_d.address               = DMemAddressQ103H;
                    req_d.data                  = DMemWrDataQ103H;
                    state_d                     = S_REQ;
                end
            end
            S_REQ: begin
                core_stall = 1'b1;
                if (C2fReqReady) begin
                    if (req_q.opcode == WR) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT: begin
                core_stall = 1'b1;
                drop_pulse = fab_is_rd_rsp && !rsp_match;
                if (rsp_match) begin
                    rsp_data_d  = InFabricQ503H.data;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_data_d  = TMO_DATA;
                    rsp_valid_d = 1'b1;
                    tmo_err_d   = 1'b1;
                    state_d     = S_RSP;
                end else begin
                    cnt_d = cnt_q + TMO_CNT_W'(1);
                end
            end
            S_RSP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
        if (Rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    assign CoreStallQ103H = core_stall;
    assign RmtRdRspValid  = rsp_valid_q;
    assign RmtRdRspData   = rsp_data_q;
    assign C2fReqValid    = (state_q == S_REQ);
    assign C2fReq         = req_q;
    assign RspDropPulse   = drop_pulse;
    assign RdTmoErr       = tmo_err_q;

    // While busy the only access the core may present is the one already captured (held by the stall).
    a_no_new_access_busy : assert property (@(posedge Clock) disable iff (Rst)
        ((state_q == S_REQ || state_q == S_WAIT) && (DMemWrEnQ103H || DMemRdEnQ103H))
        |-> (DMemAddressQ103H == req_q.address));

endmodule

// File: tb/tb_mini_rmt_rd_ctrl.sv
// Self-checking bench for mini_rmt_rd_ctrl: transaction-level model compared every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_mini_rmt_rd_ctrl;
    import mini_rmt_pkg::*;

    localparam int TMO = 1024;

    logic        Clock = 1'b0;
    logic        Rst = 1'b1;
    logic [7:0]  local_tile_id = 8'd2;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wren = 1'b0;
    logic        rden = 1'b0;
    logic        ready = 1'b0;
    logic        fab_valid = 1'b0;
    t_tile_trans fab = '0;

    logic        CoreStallQ103H;
    logic        RmtRdRspValid;
    logic [31:0] RmtRdRspData;
    logic        C2fReqValid;
    t_tile_trans C2fReq;
    logic        RspDropPulse;
    logic        RdTmoErr;

    mini_rmt_rd_ctrl dut (
        .Clock              (Clock),
        .Rst                (Rst),
        .local_tile_id      (local_tile_id),
        .DMemAddressQ103H   (addr),
        .DMemWrDataQ103H    (wdata),
        .DMemWrEnQ103H      (wren),
        .DMemRdEnQ103H      (rden),
        .CoreStallQ103H     (CoreStallQ103H),
        .RmtRdRspValid      (RmtRdRspValid),
        .RmtRdRspData       (RmtRdRspData),
        .C2fReqValid        (C2fReqValid),
        .C2fReq             (C2fReq),
        .C2fReqReady        (ready),
        .InFabricValidQ503H (fab_valid),
        .InFabricQ503H      (fab),
        .RspDropPulse       (RspDropPulse),
        .RdTmoErr           (RdTmoErr)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    // busy: an access is owned by the block; accepted: the fabric took the request.
    bit          m_busy = 0, m_accepted = 0, m_rsp = 0, m_err = 0;
    int          m_wait = 0;
    t_tile_trans m_req = '0;
    logic [31:0] m_rsp_data = '0;
    bit          cmp_en = 0;
    bit          e_hit, e_match, e_idle, e_stall, e_reqv, e_drop;

    initial forever begin
        @(negedge Clock);
        e_hit   = (wren || rden) && addr[31:24] != local_tile_id && addr[31:24] != 8'h00;
        e_match = fab_valid && fab.opcode == RD_RSP
                  && fab.address == {local_tile_id, m_req.address[23:0]}
                  && fab.requestor_id == m_req.address[31:24];
        e_idle  = !m_busy && !m_rsp;
        e_stall = m_busy || (e_idle && e_hit);
        e_reqv  = m_busy && !m_accepted;
        e_drop  = m_busy && m_accepted && fab_valid && fab.opcode == RD_RSP && !e_match;
        if (cmp_en) begin
            check("cyc_stall", CoreStallQ103H, e_stall);
            check("cyc_req_valid", C2fReqValid, e_reqv);
            check("cyc_req", C2fReq, m_req);
            check("cyc_rsp_valid", RmtRdRspValid, m_rsp);
            check("cyc_rsp_data", RmtRdRspData, m_rsp_data);
            check("cyc_drop", RspDropPulse, e_drop);
            check("cyc_tmo_err", RdTmoErr, m_err);
        end
        if (Rst) begin
            m_busy = 0; m_accepted = 0; m_rsp = 0; m_err = 0; m_wait = 0;
            m_req = '0; m_rsp_data = '0;
        end else begin
            m_rsp = 0;
            if (e_idle && e_hit) begin
                m_busy     = 1;
                m_accepted = 0;
                m_req.next_tile_fifo_arb_id = NULL_CARDINAL;
                m_req.opcode       = wren ? WR : RD;
                m_req.requestor_id = local_tile_id;
                m_req.address      = addr;
                m_req.data         = wdata;
            end else if (e_reqv) begin
                if (ready) begin
                    if (m_req.opcode == WR) m_busy = 0;
                    else begin m_accepted = 1; m_wait = 0; end
                end
            end else if (m_busy) begin
                if (e_match) begin
                    m_rsp_data = fab.data; m_busy = 0; m_rsp = 1;
                end else if (m_wait == TMO - 1) begin
                    m_rsp_data = 32'hDEAD_BEEF; m_err = 1; m_busy = 0; m_rsp = 1;
                end else begin
                    m_wait++;
                end
            end
        end
    end

    // ---------------- driver helpers (inputs change only at posedge+1) ----------------
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic core(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        addr = a; wdata = d; wren = w; rden = r;
        step();
        wren = 1'b0; rden = 1'b0;
    endtask

    task automatic accept();
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    task automatic set_fab(input t_opcode op, input logic [31:0] a, input logic [7:0] rid,
                           input logic [31:0] d);
        fab_valid = 1'b1;
        fab.next_tile_fifo_arb_id = NULL_CARDINAL;
        fab.opcode       = op;
        fab.address      = a;
        fab.requestor_id = rid;
        fab.data         = d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    t_tile_trans exp_st;
    int          k;

    initial begin
        repeat (3) step();
        Rst = 1'b0;
        cmp_en = 1;
        @(negedge Clock);
        check("rst_stall", CoreStallQ103H, 1'b0);
        check("rst_req_valid", C2fReqValid, 1'b0);
        check("rst_rsp_valid", RmtRdRspValid, 1'b0);
        check("rst_rsp_data", RmtRdRspData, 32'h0);
        check("rst_tmo_err", RdTmoErr, 1'b0);
        step();

        // 1: remote load, response 20 cycles later
        core(32'h0300_0010, 32'h0, 1'b0, 1'b1);
        ready = 1'b1;
        @(negedge Clock);
        check("s1_req_valid", C2fReqValid, 1'b1);
        check("s1_req_op", C2fReq.opcode, RD);
        check("s1_req_addr", C2fReq.address, 32'h0300_0010);
        check("s1_req_id", C2fReq.requestor_id, 8'd2);
        step();
        ready = 1'b0;
        repeat (19) step();
        set_fab(RD_RSP, 32'h0200_0010, 8'd3, 32'h1234_5678);
        @(negedge Clock);
        check("s1_stall_m", CoreStallQ103H, 1'b1);
        step();
        fab_valid = 1'b0;
        @(negedge Clock);
        check("s1_rsp_valid", RmtRdRspValid, 1'b1);
        check("s1_rsp_data", RmtRdRspData, 32'h1234_5678);
        check("s1_stall_rsp", CoreStallQ103H, 1'b0);
        step();
        @(negedge Clock);
        check("s1_rsp_pulse_end", RmtRdRspValid, 1'b0);
        check("s1_rsp_data_hold", RmtRdRspData, 32'h1234_5678);
        step();

        // 2: posted store with ready held low for 5 cycles
        exp_st.next_tile_fifo_arb_id = NULL_CARDINAL;
        exp_st.opcode       = WR;
        exp_st.requestor_id = 8'd2;
        exp_st.address      = 32'h0500_0004;
        exp_st.data         = 32'hA5A5_A5A5;
        core(32'h0500_0004, 32'hA5A5_A5A5, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            check("s2_req_valid", C2fReqValid, 1'b1);
            check("s2_req_stable", C2fReq, exp_st);
            step();
        end
        ready = 1'b1;
        @(negedge Clock);
        check("s2_stall_ready", CoreStallQ103H, 1'b1);
        step();
        ready = 1'b0;
        @(negedge Clock);
        check("s2_stall_after", CoreStallQ103H, 1'b0);
        check("s2_no_rsp", RmtRdRspValid, 1'b0);
        check("s2_req_valid_after", C2fReqValid, 1'b0);
        step();

        // 3: wrong offset dropped, then correct response accepted
        core(32'h0700_0010, 32'h0, 1'b0, 1'b1);
        accept();
        step();
        set_fab(RD_RSP, 32'h0200_0014, 8'd7, 32'h1111_1111);
        @(negedge Clock);
        check("s3_drop", RspDropPulse, 1'b1);
        step();
        set_fab(RD_RSP, 32'h0200_0010, 8'd7, 32'h2222_2222);
        @(negedge Clock);
        check("s3_no_drop", RspDropPulse, 1'b0);
        step();
        fab_valid = 1'b0;
        @(negedge Clock);
        check("s3_rsp_valid", RmtRdRspValid, 1'b1);
        check("s3_rsp_data", RmtRdRspData, 32'h2222_2222);
        step();

        // 4: timeout after 1024 WAIT cycles, late response ignored, error sticky
        core(32'h0900_0020, 32'h0, 1'b0, 1'b1);
        accept();
        for (k = 0; k < 1200; k++) begin
            @(negedge Clock);
            if (RmtRdRspValid) break;
            step();
        end
        check("s4_tmo_latency", k, 1024);
        check("s4_tmo_data", RmtRdRspData, 32'hDEAD_BEEF);
        check("s4_tmo_err", RdTmoErr, 1'b1);
        step();
        set_fab(RD_RSP, 32'h0200_0020, 8'd9, 32'h3333_3333);
        @(negedge Clock);
        check("s4_late_no_drop", RspDropPulse, 1'b0);
        step();
        fab_valid = 1'b0;
        @(negedge Clock);
        check("s4_late_no_rsp", RmtRdRspValid, 1'b0);
        check("s4_err_sticky", RdTmoErr, 1'b1);
        step();

        // 5: reset while waiting abandons the access
        core(32'h0400_0008, 32'h0, 1'b0, 1'b1);
        accept();
        step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        @(negedge Clock);
        check("s5_stall", CoreStallQ103H, 1'b0);
        check("s5_req_valid", C2fReqValid, 1'b0);
        check("s5_req", C2fReq, 77'h0);
        check("s5_err_cleared", RdTmoErr, 1'b0);
        check("s5_rsp_data", RmtRdRspData, 32'h0);
        step();
        set_fab(RD_RSP, 32'h0200_0008, 8'd4, 32'h4444_4444);
        step();
        fab_valid = 1'b0;
        @(negedge Clock);
        check("s5_late_ignored", RmtRdRspValid, 1'b0);
        step();

        // match on the terminal WAIT cycle wins over the timeout
        core(32'h0600_000C, 32'h0, 1'b0, 1'b1);
        accept();
        repeat (TMO - 1) step();
        set_fab(RD_RSP, 32'h0200_000C, 8'd6, 32'hCAFE_F00D);
        step();
        fab_valid = 1'b0;
        @(negedge Clock);
        check("term_rsp_valid", RmtRdRspValid, 1'b1);
        check("term_rsp_data", RmtRdRspData, 32'hCAFE_F00D);
        check("term_no_err", RdTmoErr, 1'b0);
        step();

        // 6: tile-0 and local accesses never stall
        addr = 32'h0000_0040; rden = 1'b1;
        @(negedge Clock);
        check("s6_tile0_stall", CoreStallQ103H, 1'b0);
        step();
        addr = 32'h0200_0040;
        @(negedge Clock);
        check("s6_local_stall", CoreStallQ103H, 1'b0);
        step();
        rden = 1'b0;
        @(negedge Clock);
        check("s6_req_valid", C2fReqValid, 1'b0);
        step();

        // randomized traffic; the per-cycle model comparison does the checking
        for (int t = 0; t < 150; t++) begin
            logic [7:0]  tile;
            logic [31:0] a;
            logic        w, r, hit;
            int          sel;
            sel  = $urandom_range(0, 7);
            tile = (sel == 0) ? 8'h00 : (sel == 1) ? local_tile_id : 8'($urandom_range(3, 255));
            a    = {tile, 24'($urandom)};
            w    = 1'($urandom_range(0, 1));
            r    = w ? 1'($urandom_range(0, 1)) : 1'b1;
            hit  = (tile != 8'h00) && (tile != local_tile_id);
            core(a, $urandom, w, r);
            if (!hit) continue;
            repeat ($urandom_range(0, 4)) begin
                if ($urandom_range(0, 1) == 1) set_fab(RD_RSP, $urandom, 8'($urandom), $urandom);
                step();
                fab_valid = 1'b0;
            end
            accept();
            if (w) continue;
            repeat ($urandom_range(0, 3)) begin
                case ($urandom_range(0, 3))
                    0: set_fab(RD_RSP, {local_tile_id, a[23:0] ^ 24'h4}, tile, $urandom);
                    1: set_fab(RD_RSP, {local_tile_id, a[23:0]}, tile ^ 8'h01, $urandom);
                    2: set_fab(RD_RSP, {local_tile_id ^ 8'h80, a[23:0]}, tile, $urandom);
                    default: set_fab(t_opcode'($urandom_range(0, 1) ? WR_RSP : WR),
                                     {local_tile_id, a[23:0]}, tile, $urandom);
                endcase
                step();
                fab_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            set_fab(RD_RSP, {local_tile_id, a[23:0]}, tile, $urandom);
            step();
            fab_valid = 1'b0;
            step();
        end
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
